key_sequencer: RTL and testbench

KEY_SEQUENCER -- requirements
Module: key_sequencer

---
 rtl/keylock_pkg.sv | 37 +++
 rtl/digit_extract.sv | 88 ++++++++
 rtl/key_sequencer.sv | 167 ++++++++++++++++
 tb/tb_key_sequencer.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/keylock_pkg.sv
// Shared definitions for the keypad code sequencer: key width, default
// digit count, state encodings and the powers-of-ten table.
package keylock_pkg;

    localparam int KEY_W              = 4;
    localparam int NUM_DIGITS_DEFAULT = 6;

    // Sequencer states, walked through in this order for a successful code
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONV,
        ST_EMIT,
        ST_GAP,
        ST_FINISH
    } seq_state_e;

    // Digit extractor states
    typedef enum logic {
        EX_IDLE,
        EX_RUN
    } ext_state_e;

    // 10^k for k = 0..9; element [k] holds 10^k, so NUM_DIGITS must stay <= 9
    localparam logic [9:0][31:0] POW10 = {
        32'd1000000000,
        32'd100000000,
        32'd10000000,
        32'd1000000,
        32'd100000,
        32'd10000,
        32'd1000,
        32'd100,
        32'd10,
        32'd1
    };

endpackage

// File: rtl/digit_extract.sv
// Binary-to-decimal digit extraction by repeated subtraction, MSD first.
// Each position costs (digit + 1) cycles: one per subtraction plus one to
// store the digit and move on. The caller must only start it with
// code < 10^NUM_DIGITS, otherwise the top digit counter would overflow.
module digit_extract
    import keylock_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT
) (
    input  logic                              hwclk,
    input  logic                              reset,
    input  logic                              start,
    input  logic [31:0]                       code,
    output logic                              done,
    output logic [NUM_DIGITS-1:0][KEY_W-1:0]  digits
);

    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    ext_state_e                        state_q, state_d;
    logic [31:0]                       rem_q, rem_d;
    logic [POS_W-1:0]                  pos_q, pos_d;
    logic [KEY_W-1:0]                  cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][KEY_W-1:0]  digits_q, digits_d;
    logic                              done_q, done_d;
    logic [31:0]                       pow_sel;

    // Next-state logic: load on start, then subtract or advance one step per cycle
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        pos_d    = pos_q;
        cnt_d    = cnt_q;
        digits_d = digits_q;
        done_d   = 1'b0;
        pow_sel  = POW10[pos_q];
        case (state_q)
            EX_IDLE: begin
                if (start) begin
                    rem_d    = code;
                    pos_d    = POS_W'(NUM_DIGITS - 1);
                    cnt_d    = '0;
                    digits_d = '0;
                    state_d  = EX_RUN;
                end
            end
            EX_RUN: begin
                if (rem_q >= pow_sel) begin
                    rem_d = rem_q - pow_sel;
                    cnt_d = cnt_q + 1'b1;
                end else begin
                    digits_d[pos_q] = cnt_q;
                    cnt_d           = '0;
                    if (pos_q == '0) begin
                        done_d  = 1'b1;
                        state_d = EX_IDLE;
                    end else begin
                        pos_d = pos_q - 1'b1;
                    end
                end
            end
            default: state_d = EX_IDLE;
        endcase
    end

    // Extraction registers, cleared asynchronously by reset
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q  <= EX_IDLE;
            rem_q    <= '0;
            pos_q    <= '0;
            cnt_q    <= '0;
            digits_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            pos_q    <= pos_d;
            cnt_q    <= cnt_d;
            digits_q <= digits_d;
            done_q   <= done_d;
        end
    end

    assign done   = done_q;
    assign digits = digits_q;

endmodule

// File: rtl/key_sequencer.sv
// Turns a binary code into a sequence of keypad strobes (keys 1..9), one
// per decimal digit MSD first, separated by GAP_CYCLES idle cycles. The
// whole code is validated before the first strobe so a sequence is either
// emitted completely or not at all. All outputs come straight from flops.
module key_sequencer
    import keylock_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEFAULT,
    parameter int GAP_CYCLES = 1200000
) (
    input  logic              hwclk,
    input  logic              reset,
    input  logic              start,
    input  logic [31:0]       code,
    output logic [KEY_W-1:0]  button,
    output logic              bstate,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int              POS_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int              GAP_W      = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;
    localparam bit              HAS_GAP    = (GAP_CYCLES > 0);
    localparam logic [31:0]     CODE_LIMIT = POW10[NUM_DIGITS];

    seq_state_e                        state_q, state_d;
    logic [KEY_W-1:0]                  button_q, button_d;
    logic                              bstate_q, bstate_d;
    logic                              busy_q, busy_d;
    logic                              done_q, done_d;
    logic                              error_q, error_d;
    logic [POS_W-1:0]                  idx_q, idx_d;
    logic [GAP_W-1:0]                  gap_cnt_q, gap_cnt_d;
    logic [POS_W-1:0]                  idx_dec;
    logic                              ext_start;
    logic                              ext_done;
    logic [NUM_DIGITS-1:0][KEY_W-1:0]  ext_digits;
    logic                              any_zero;

    digit_extract #(
        .NUM_DIGITS (NUM_DIGITS)
    ) u_extract (
        .hwclk  (hwclk),
        .reset  (reset),
        .start  (ext_start),
        .code   (code),
        .done   (ext_done),
        .digits (ext_digits)
    );

    // A zero digit has no key on the 3x3 pad, which rejects the whole code
    always_comb begin
        any_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (ext_digits[k] == '0) begin
                any_zero = 1'b1;
            end
        end
    end

    // Sequencer next state; strobe and key are set on the transition into EMIT
    always_comb begin
        state_d   = state_q;
        button_d  = button_q;
        bstate_d  = 1'b0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        error_d   = error_q;
        idx_d     = idx_q;
        gap_cnt_d = gap_cnt_q;
        ext_start = 1'b0;
        idx_dec   = idx_q - 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (code < CODE_LIMIT) begin
                        error_d   = 1'b0;
                        ext_start = 1'b1;
                        state_d   = ST_CONV;
                    end else begin
                        error_d = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_CONV: begin
                if (ext_done) begin
                    if (any_zero) begin
                        error_d = 1'b1;
                        state_d = ST_FINISH;
                    end else begin
                        idx_d    = POS_W'(NUM_DIGITS - 1);
                        button_d = ext_digits[NUM_DIGITS-1];
                        bstate_d = 1'b1;
                        state_d  = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (HAS_GAP) begin
                    gap_cnt_d = '0;
                    state_d   = ST_GAP;
                end else if (idx_q == '0) begin
                    state_d = ST_FINISH;
                end else begin
                    idx_d    = idx_dec;
                    button_d = ext_digits[idx_dec];
                    bstate_d = 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = ST_FINISH;
                    end else begin
                        idx_d    = idx_dec;
                        button_d = ext_digits[idx_dec];
                        bstate_d = 1'b1;
                        state_d  = ST_EMIT;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously by reset
    always_ff @(posedge hwclk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            button_q  <= '0;
            bstate_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            idx_q     <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            button_q  <= button_d;
            bstate_q  <= bstate_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            idx_q     <= idx_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    assign button = button_q;
    assign bstate = bstate_q;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;

endmodule

// File: tb/tb_key_sequencer.sv
// Self-checking bench for key_sequencer: directed scenarios plus random
// codes, compared against a decimal-arithmetic reference model.
module tb_key_sequencer;

    localparam int NUM_DIGITS = 6;
    localparam int GAP_CYCLES = 4;
    localparam int SPACING    = GAP_CYCLES + 1;
    localparam int WAIT_BOUND = 400;

    logic        hwclk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] code;
    logic [3:0]  button;
    logic        bstate;
    logic        busy;
    logic        done;
    logic        error;

    int checks     = 0;
    int errors     = 0;
    int cyc        = 0;
    int done_seen  = 0;
    int runs       = 0;
    int strobe_btn[$];
    int strobe_cyc[$];

    // Reference model results for the code under test
    int exp_digits[$];
    int exp_conv;
    bit exp_range;
    bit exp_zero;

    key_sequencer #(
        .NUM_DIGITS (NUM_DIGITS),
        .GAP_CYCLES (GAP_CYCLES)
    ) dut (
        .hwclk  (hwclk),
        .reset  (reset),
        .start  (start),
        .code   (code),
        .button (button),
        .bstate (bstate),
        .busy   (busy),
        .done   (done),
        .error  (error)
    );

    // 10 ns clock
    always #5 hwclk = ~hwclk;

    // Cycle index, advanced on every active edge
    always @(posedge hwclk) cyc <= cyc + 1;

    // Record every strobe and every done cycle away from the active edge
    always @(negedge hwclk) begin
        if (bstate === 1'b1) begin
            strobe_btn.push_back(int'(button));
            strobe_cyc.push_back(cyc);
        end
        if (done === 1'b1) done_seen++;
    end

    // Hang guard
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Decimal digits MSD first, conversion length and error classification
    function automatic void modelCode(input longint c);
        longint v;
        longint limit;
        int     d;
        exp_digits.delete();
        exp_conv = 0;
        exp_zero = 0;
        limit    = 1;
        for (int i = 0; i < NUM_DIGITS; i++) limit = limit * 10;
        exp_range = (c >= limit);
        v = c;
        if (!exp_range) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                d = int'(v % 10);
                v = v / 10;
                exp_digits.push_front(d);
                exp_conv += d + 1;
                if (d == 0) exp_zero = 1;
            end
        end
    endfunction

    // Issue one code after 'idle' cycles, optionally re-pulse start at an offset, and check the run
    task automatic applyStimulus(input logic [31:0] c, input int idle, input int inject_at);
        int accept_cyc;
        int done_cyc;
        int exp_done;
        int n_exp;
        bit got_done;
        modelCode(longint'(c));
        strobe_btn.delete();
        strobe_cyc.delete();
        repeat (idle) @(negedge hwclk);
        start = 1'b1;
        code  = c;
        @(posedge hwclk);
        #1;
        start      = 1'b0;
        code       = $urandom;
        accept_cyc = cyc;
        checkOutput("busy_after_start", busy, 1);
        checkOutput("error_after_start", error, exp_range);
        got_done = 0;
        done_cyc = 0;
        for (int i = 0; i < WAIT_BOUND && !got_done; i++) begin
            @(negedge hwclk);
            if (inject_at > 0 && (cyc - accept_cyc) == inject_at) begin
                start = 1'b1;
                code  = 32'd111111;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        start = 1'b0;
        runs++;
        checkOutput("done_timeout", got_done, 1);
        if (got_done) begin
            if (exp_range)      exp_done = 1;
            else if (exp_zero)  exp_done = exp_conv + 2;
            else                exp_done = exp_conv + 1 + NUM_DIGITS * SPACING + 1;
            n_exp = (exp_range || exp_zero) ? 0 : NUM_DIGITS;
            checkOutput("done_latency", done_cyc - accept_cyc, exp_done);
            checkOutput("busy_at_done", busy, 0);
            checkOutput("error_at_done", error, (exp_range || exp_zero));
            checkOutput("strobe_count", strobe_btn.size(), n_exp);
            if (n_exp > 0 && strobe_btn.size() == n_exp) begin
                checkOutput("first_strobe_latency", strobe_cyc[0] - accept_cyc, exp_conv + 1);
                for (int k = 0; k < n_exp; k++) begin
                    checkOutput("button_value", strobe_btn[k], exp_digits[k]);
                    if (k > 0) checkOutput("strobe_spacing", strobe_cyc[k] - strobe_cyc[k-1], SPACING);
                end
                checkOutput("button_hold", button, exp_digits[NUM_DIGITS-1]);
            end
        end
    endtask

    // Start 555116, assert reset right after the third strobe and confirm the abort
    task automatic runResetAbort();
        int seen;
        int done_before;
        strobe_btn.delete();
        strobe_cyc.delete();
        @(negedge hwclk);
        start = 1'b1;
        code  = 32'd555116;
        @(posedge hwclk);
        #1;
        start = 1'b0;
        seen  = 0;
        for (int i = 0; i < WAIT_BOUND && seen < 3; i++) begin
            @(negedge hwclk);
            if (bstate === 1'b1) seen++;
        end
        checkOutput("abort_third_strobe", seen, 3);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort_button", button, 0);
        checkOutput("abort_bstate", bstate, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_error", error, 0);
        done_before = done_seen;
        repeat (3) @(negedge hwclk);
        reset = 1'b0;
        repeat (100) @(negedge hwclk);
        checkOutput("abort_no_more_strobes", strobe_btn.size(), 3);
        checkOutput("abort_no_done", done_seen, done_before);
        checkOutput("abort_idle_busy", busy, 0);
    endtask

    initial begin
        logic [31:0] c;
        int          kind;
        reset = 1'b1;
        start = 1'b0;
        code  = '0;
        repeat (3) @(negedge hwclk);
        checkOutput("reset_button", button, 0);
        checkOutput("reset_bstate", bstate, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_error", error, 0);
        reset = 1'b0;
        @(negedge hwclk);

        applyStimulus(32'd555116, 1, -1);
        applyStimulus(32'd666666, 0, -1);
        applyStimulus(32'd123450, 2, -1);
        applyStimulus(32'd1000000, 0, -1);
        applyStimulus(32'd999999, 1, -1);
        applyStimulus(32'd0, 0, -1);
        applyStimulus(32'd555116, 1, 32);
        runResetAbort();
        applyStimulus(32'd999999, 0, -1);

        for (int r = 0; r < 20; r++) begin
            kind = $urandom_range(0, 3);
            if (kind <= 1) begin
                c = 0;
                for (int k = 0; k < NUM_DIGITS; k++) c = c * 10 + $urandom_range(1, 9);
            end else if (kind == 2) begin
                c = $urandom_range(0, 999999);
            end else begin
                c = $urandom;
                if (c < 32'd1000000) c = c + 32'd1000000;
            end
            applyStimulus(c, $urandom_range(0, 3), -1);
        end

        repeat (2) @(negedge hwclk);
        checkOutput("done_pulse_total", done_seen, runs);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
